ins_dispatcher: RTL
===================

# ins_dispatcher

Instruction issue stage that sits directly upstream of the DSP `controller`. It accepts 32-bit instructions from the host over a valid/ready push interface and buffers them in a DEPTH-entry FIFO. It issues them one at a time to the controller through a single-cycle enable pulse, and issues the next only after the controller reports completion. It also exposes FIFO occupancy, a completion counter, an idle flag and an optional stall counter for host polling.

## Interface
- DEPTH, 8, FIFO entries; power of two, >= 2
- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- s_ins_valid_i  input  1  host instruction valid
- s_ins_data_i  input  32  host instruction word
- s_ins_ready_o  output  1  FIFO can accept; equals !full
- ctrl_en_o  output  1  one-cycle issue pulse to controller `en_i`
- ctrl_ins_o  output  32  instruction to controller `ins_i`; held stable until next issue
- ctrl_busy_i  input  1  controller `busy_o`
- ctrl_valid_i  input  1  controller `valid_o`, completion pulse
- flush_i  input  1  discard all queued (not in-flight) instructions
- fifo_count_o  output  $clog2(DEPTH)+1  entries currently queued
- done_cnt_o  output  16  completed instructions, wraps 0xFFFF->0
- idle_o  output  1  FIFO empty and FSM in IDLE
- stall_cnt_o  output  32  stall cycles (see Configuration)

## Operation
- Push: entry written when s_ins_valid_i && s_ins_ready_o && !flush_i && !rst_i. s_ins_ready_o is a pure function of the registered count (no path from pop).
- Pop happens only on the FSM transition IDLE->ISSUE. Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo DEPTH.
- FSM states:
  - IDLE -> ISSUE when FIFO non-empty && !ctrl_busy_i. On this edge, pop the head into the ctrl_ins_o register.
  - ISSUE -> WAIT unconditionally. ctrl_en_o = (state == ISSUE), registered.
  - WAIT -> IDLE on ctrl_valid_i. On the same edge done_cnt_o increments.
- ctrl_valid_i outside WAIT is ignored; done_cnt_o does not change.
- ctrl_busy_i is ignored in ISSUE and WAIT.
- Flush: on an edge with flush_i high, the count and pointers go to 0. A simultaneous push is dropped. A simultaneous pop (IDLE->ISSUE) still issues the popped head. An in-flight instruction in ISSUE or WAIT is not aborted and completes normally.
- idle_o = (state == IDLE) && count == 0.
- Reset: state IDLE, pointers and count 0, ctrl_en_o 0, ctrl_ins_o 0, done_cnt_o 0, stall_cnt_o 0. s_ins_ready_o reads 1 and idle_o reads 1 during and after reset. Pushes while rst_i is high are ignored. Reset mid-operation discards the queue and the in-flight tracking; no completion is counted.

## Timing
- Push accepted at edge E into an empty FIFO with the FSM in IDLE and ctrl_busy_i low:
  - fifo_count_o = 1 after E
  - IDLE->ISSUE at E+1
  - ctrl_en_o high from E+1 to E+2, with ctrl_ins_o valid from E+1
- Minimum issue interval: 3 cycles (ISSUE, WAIT with same-cycle valid, IDLE).
- ctrl_en_o is never high for two consecutive cycles.
- Completion latency is set by the controller; the dispatcher has no timeout.

## Configuration
- DISPATCH_STALL_CNT_EN defined: stall_cnt_o increments (wrapping at 2^32) every cycle where state == IDLE, FIFO non-empty and ctrl_busy_i is high. It is cleared by reset only.
- Not defined: stall_cnt_o is tied to 0 and the counter logic is absent. The port list is unchanged.

## Test plan
- Single issue: push 0xA5A5_0001 with ctrl_busy_i=0.
  - ctrl_en_o pulses exactly one cycle, one cycle after the push edge, with ctrl_ins_o = 0xA5A5_0001.
  - Pulse ctrl_valid_i two cycles later -> done_cnt_o = 1, idle_o = 1.
- Fill/full with DEPTH=8: hold ctrl_busy_i=1 and push 9 words in consecutive cycles.
  - 8 accepted, s_ins_ready_o = 0 after the 8th, fifo_count_o = 8, 9th not stored.
  - With DISPATCH_STALL_CNT_EN defined, stall_cnt_o counts the busy cycles.
- In-order drain: release ctrl_busy_i and acknowledge each issue 1 cycle after its ctrl_en_o.
  - 8 issues in push order, at least 3 cycles apart.
  - done_cnt_o = 8, fifo_count_o = 0.
- Simultaneous push/pop: push in the cycle of IDLE->ISSUE with count 3 -> count stays 3.
- Flush mid-operation: 4 queued, one in WAIT, assert flush_i plus a push.
  - fifo_count_o = 0 and the push is dropped.
  - The in-flight instruction completes, done_cnt_o +1, no further ctrl_en_o.
- Reset mid-WAIT: assert rst_i for 1 cycle.
  - All outputs return to their reset values.
  - A later stray ctrl_valid_i leaves done_cnt_o = 0.

Source files
------------

// File: rtl/ins_dispatcher.sv
// ---------------------------------------------------------------------------
// ins_dispatcher
//
// Instruction issue stage in front of the DSP controller. Host instructions
// are pushed over a valid/ready interface into a DEPTH-entry FIFO and issued
// to the controller one at a time with a single-cycle enable pulse. The next
// instruction is issued only after the controller signals completion.
//
// Ports:
//   clk_i          rising-edge clock
//   rst_i          synchronous active-high reset
//   s_ins_valid_i  host instruction valid
//   s_ins_data_i   host instruction word (32 bit)
//   s_ins_ready_o  FIFO can accept (not full)
//   ctrl_en_o      one-cycle issue pulse to the controller
//   ctrl_ins_o     issued instruction, held until the next issue
//   ctrl_busy_i    controller busy; blocks issue from IDLE only
//   ctrl_valid_i   controller completion pulse; honoured only in WAIT
//   flush_i        discard queued (not in-flight) instructions
//   fifo_count_o   number of queued entries
//   done_cnt_o     completed instructions, 16-bit wrapping
//   idle_o         FIFO empty and FSM in IDLE
//   stall_cnt_o    stall cycles (busy while work is queued)
//
// Configuration macro:
//   DISPATCH_STALL_CNT_EN  when defined, stall_cnt_o counts cycles spent in
//                          IDLE with a non-empty FIFO and ctrl_busy_i high.
//                          When undefined, stall_cnt_o is tied to zero.
// ---------------------------------------------------------------------------
module ins_dispatcher #(
    parameter int DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     s_ins_valid_i,
    input  logic [31:0]              s_ins_data_i,
    output logic                     s_ins_ready_o,
    output logic                     ctrl_en_o,
    output logic [31:0]              ctrl_ins_o,
    input  logic                     ctrl_busy_i,
    input  logic                     ctrl_valid_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   fifo_count_o,
    output logic [15:0]              done_cnt_o,
    output logic                     idle_o,
    output logic [31:0]              stall_cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [31:0]     mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            ctrl_en_r;
    logic [31:0]     ctrl_ins_r;
    logic [15:0]     done_cnt_r;
    logic            push_s;
    logic            pop_s;
    logic            complete_s;

    // Ready depends only on the registered count, so no combinational path
    // exists from the issue side back to the host.
    assign s_ins_ready_o = (count_r != CW'(DEPTH));
    assign push_s        = s_ins_valid_i && s_ins_ready_o && !flush_i && !rst_i;
    assign idle_o        = (state_r == ST_IDLE) && (count_r == {CW{1'b0}});
    assign fifo_count_o  = count_r;
    assign ctrl_en_o     = ctrl_en_r;
    assign ctrl_ins_o    = ctrl_ins_r;
    assign done_cnt_o    = done_cnt_r;

    // Next-state logic; pop and completion are decoded from the transitions.
    always_comb begin
        state_next_s = state_r;
        pop_s        = 1'b0;
        complete_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if ((count_r != {CW{1'b0}}) && !ctrl_busy_i) begin
                    state_next_s = ST_ISSUE;
                    pop_s        = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_next_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (ctrl_valid_i) begin
                    state_next_s = ST_IDLE;
                    complete_s   = 1'b1;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FIFO storage; no reset needed since count gates every read.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= s_ins_data_i;
        end
    end

    // FIFO pointers and occupancy. Flush clears the queue but a same-edge
    // pop has already captured the head into the issue register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush_i) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Issue pulse, issued instruction and completion counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ctrl_en_r  <= 1'b0;
            ctrl_ins_r <= 32'h0000_0000;
            done_cnt_r <= 16'h0000;
        end else begin
            ctrl_en_r <= (state_next_s == ST_ISSUE);
            if (pop_s) begin
                ctrl_ins_r <= mem_r[rd_ptr_r];
            end
            if (complete_s) begin
                done_cnt_r <= done_cnt_r + 16'd1;
            end
        end
    end

`ifdef DISPATCH_STALL_CNT_EN
    logic [31:0] stall_cnt_r;

    // Stall counter: work is queued but the controller holds us off.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_r <= 32'h0000_0000;
        end else if ((state_r == ST_IDLE) && (count_r != {CW{1'b0}}) && ctrl_busy_i) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_r;
`else
    assign stall_cnt_o = 32'h0000_0000;
`endif

endmodule
